// File: rtl/sti_dac_pkg.sv
// Package for the serial DAC bank writer.
// Holds the FSM state encoding and the frame-length decode shared by the
// top level and the bench. The STI_DAC_PARITY_EN macro is consumed in the top-level file.
package sti_dac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    SHIFT = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] LEN_BITS_8  = 6'd8;
  localparam logic [5:0] LEN_BITS_16 = 6'd16;
  localparam logic [5:0] LEN_BITS_24 = 6'd24;
  localparam logic [5:0] LEN_BITS_32 = 6'd32;

  // Length code 0..3 -> number of serialized frame bits.
  function automatic logic [5:0] len_to_bits(input logic [1:0] code);
    case (code)
      2'd0:    return LEN_BITS_8;
      2'd1:    return LEN_BITS_16;
      2'd2:    return LEN_BITS_24;
      default: return LEN_BITS_32;
    endcase
  endfunction

endpackage

// File: rtl/sti_dac_bank_map.sv
// Combinational byte-index -> memory location mapping.
// Ports:
//   i_p       byte index (0 .. NUM_BANK*2*BANK_DEPTH-1)
//   o_bank    bank pair index = p / (2*BANK_DEPTH)
//   o_addr    word address inside the bank = (p % (2*BANK_DEPTH)) / 2
//   o_sel_odd 1 -> odd memory, 0 -> even memory (checkerboard on row+col)
module sti_dac_bank_map #(
  parameter int NUM_BANK   = 4,
  parameter int BANK_DEPTH = 32,
  parameter int IMG_W      = 8,
  parameter int AW         = $clog2(BANK_DEPTH),
  parameter int BW         = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  parameter int MW         = $clog2(NUM_BANK * 2 * BANK_DEPTH)
) (
  input  logic [MW-1:0] i_p,
  output logic [BW-1:0] o_bank,
  output logic [AW-1:0] o_addr,
  output logic          o_sel_odd
);

  localparam int IWL = $clog2(IMG_W);

  // Bank depth and image width are powers of two, so division and modulo
  // reduce to bit selects.
  assign o_bank = BW'(i_p >> (AW + 1));
  assign o_addr = AW'(i_p >> 1);

  // (row + col) is even exactly when the LSBs of row and col match.
  generate
    if (IWL == 0) begin : g_one_col
      assign o_sel_odd = ~i_p[0];
    end else begin : g_multi_col
      assign o_sel_odd = ~(i_p[IWL] ^ i_p[0]);
    end
  endgenerate

endmodule

// File: rtl/sti_dac_bank_writer.sv
// Serial transmitter plus DAC bank writer.
// Accepts one 16-bit word per handshake, formats it into an 8/16/24/32-bit
// frame, shifts it out MSB- or LSB-first, packs every 8 serialized bits into a
// byte and writes it to odd/even memory pairs in checkerboard order. pi_end
// pads all remaining capacity with zero bytes, then oem_finish rises (sticky).
// Optional feature macro: STI_DAC_PARITY_EN (trailing parity bit per frame).
// Handshake: a word transfers on a rising clk edge where load && pi_ready;
//   pi_ready is high only in IDLE and pi_end wins over load in that cycle.
// Ports:
//   clk, reset (async active-low)
//   load, pi_ready, pi_data, pi_length, pi_msb, pi_low, pi_fill, pi_end : word input
//   so_data, so_valid, so_parity                                      : serial output
//   odd_wr, even_wr, oem_addr, oem_dataout, oem_finish                : memory write side
//   o_state                                                           : FSM state, debug
module sti_dac_bank_writer
  import sti_dac_pkg::*;
#(
  parameter int NUM_BANK   = 4,
  parameter int BANK_DEPTH = 32,
  parameter int IMG_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  output logic                          pi_ready,
  input  logic [15:0]                   pi_data,
  input  logic [1:0]                    pi_length,
  input  logic                          pi_msb,
  input  logic                          pi_low,
  input  logic                          pi_fill,
  input  logic                          pi_end,
  output logic                          so_data,
  output logic                          so_valid,
  output logic                          so_parity,
  output logic [NUM_BANK-1:0]           odd_wr,
  output logic [NUM_BANK-1:0]           even_wr,
  output logic [$clog2(BANK_DEPTH)-1:0] oem_addr,
  output logic [7:0]                    oem_dataout,
  output logic                          oem_finish,
  output state_t                        o_state
);

  localparam int AW  = $clog2(BANK_DEPTH);
  localparam int BW  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int CAP = NUM_BANK * 2 * BANK_DEPTH;
  localparam int MW  = $clog2(CAP);
  localparam int PW  = $clog2(CAP + 1);
  localparam logic [PW-1:0]       CAP_P = PW'(CAP);
  localparam logic [NUM_BANK-1:0] ONE_B = NUM_BANK'(1);

  state_t r_state, w_next;

  logic [15:0] r_data;
  logic [1:0]  r_len;
  logic        r_msb, r_low, r_fill;
  logic [31:0] r_sh;
  logic [5:0]  r_cnt;
  logic [7:0]  r_byte;
  logic [2:0]  r_bitcnt;
  logic [PW-1:0] r_p;
  logic [NUM_BANK-1:0] r_odd_wr, r_even_wr;
  logic [AW-1:0] r_addr;
  logic [7:0]  r_dout;
  logic        r_finish;

  logic [31:0] w_frame;
  logic [5:0]  w_bits;
  logic        w_accept, w_bit, w_push, w_push_bit, w_par_phase, w_par_bit;
  logic [BW-1:0] w_bank;
  logic [AW-1:0] w_addr;
  logic        w_sel_odd;

  sti_dac_bank_map #(
    .NUM_BANK  (NUM_BANK),
    .BANK_DEPTH(BANK_DEPTH),
    .IMG_W     (IMG_W)
  ) u_map (
    .i_p      (r_p[MW-1:0]),
    .o_bank   (w_bank),
    .o_addr   (w_addr),
    .o_sel_odd(w_sel_odd)
  );

  assign w_accept = (r_state == IDLE) && load && !pi_end;
  assign w_bits   = len_to_bits(r_len);
  assign w_bit    = r_msb ? r_sh[31] : r_sh[0];

  // Frame value, right-aligned in 32 bits, from the captured configuration.
  always_comb begin
    w_frame = 32'h0;
    case (r_len)
      2'd0: w_frame = {24'h0, (r_low ? r_data[15:8] : r_data[7:0])};
      2'd1: w_frame = {16'h0, r_data};
      2'd2: w_frame = r_fill ? {8'h0, r_data, 8'h0} : {16'h0, r_data};
      default: w_frame = r_fill ? {r_data, 16'h0} : {16'h0, r_data};
    endcase
  end

`ifdef STI_DAC_PARITY_EN
  logic r_par, r_par_phase;

  // Running XOR of the frame bits; the extra SHIFT cycle emits it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par       <= 1'b0;
      r_par_phase <= 1'b0;
    end else if (r_state == CONV) begin
      r_par       <= 1'b0;
      r_par_phase <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (!r_par_phase) begin
        r_par <= r_par ^ w_bit;
        if (r_cnt == 6'd1) r_par_phase <= 1'b1;
      end else begin
        r_par_phase <= 1'b0;
      end
    end
  end

  assign w_par_phase = r_par_phase;
  assign w_par_bit   = r_par;
`else
  assign w_par_phase = 1'b0;
  assign w_par_bit   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (pi_end)    w_next = PAD;
        else if (load) w_next = CONV;
      end
      CONV:  w_next = SHIFT;
      SHIFT: begin
        if (w_par_phase) begin
          w_next = IDLE;
        end else if (r_cnt == 6'd1) begin
`ifdef STI_DAC_PARITY_EN
          w_next = SHIFT;
`else
          w_next = IDLE;
`endif
        end
      end
      PAD:     if (r_p == CAP_P) w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Zero bits fill the byte assembler while padding.
  assign w_push     = ((r_state == SHIFT) && !w_par_phase) || (r_state == PAD);
  assign w_push_bit = (r_state == SHIFT) ? w_bit : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data    <= 16'h0;
      r_len     <= 2'd0;
      r_msb     <= 1'b0;
      r_low     <= 1'b0;
      r_fill    <= 1'b0;
      r_sh      <= 32'h0;
      r_cnt     <= 6'd0;
      r_byte    <= 8'h0;
      r_bitcnt  <= 3'd0;
      r_p       <= '0;
      r_odd_wr  <= '0;
      r_even_wr <= '0;
      r_addr    <= '0;
      r_dout    <= 8'h0;
      r_finish  <= 1'b0;
    end else begin
      r_odd_wr  <= '0;
      r_even_wr <= '0;
      r_finish  <= r_finish | (r_p == CAP_P);

      if (w_accept) begin
        r_data <= pi_data;
        r_len  <= pi_length;
        r_msb  <= pi_msb;
        r_low  <= pi_low;
        r_fill <= pi_fill;
      end

      // MSB-first frames are left-aligned so bit 31 is always the next bit.
      if (r_state == CONV) begin
        r_sh  <= r_msb ? (w_frame << (6'd32 - w_bits)) : w_frame;
        r_cnt <= w_bits;
      end else if ((r_state == SHIFT) && !w_par_phase) begin
        r_sh  <= r_msb ? (r_sh << 1) : (r_sh >> 1);
        r_cnt <= r_cnt - 6'd1;
      end

      if (w_push) begin
        r_byte   <= {r_byte[6:0], w_push_bit};
        r_bitcnt <= r_bitcnt + 3'd1;
        if ((r_bitcnt == 3'd7) && (r_p != CAP_P)) begin
          r_dout <= {r_byte[6:0], w_push_bit};
          r_addr <= w_addr;
          r_p    <= r_p + PW'(1);
          if (w_sel_odd) r_odd_wr  <= ONE_B << w_bank;
          else           r_even_wr <= ONE_B << w_bank;
        end
      end
    end
  end

  assign pi_ready    = (r_state == IDLE);
  assign so_valid    = (r_state == SHIFT);
  assign so_data     = (r_state == SHIFT) ? (w_par_phase ? w_par_bit : w_bit) : 1'b0;
  assign so_parity   = (r_state == SHIFT) && w_par_phase;
  assign odd_wr      = r_odd_wr;
  assign even_wr     = r_even_wr;
  assign oem_addr    = r_addr;
  assign oem_dataout = r_dout;
  assign oem_finish  = r_finish;
  assign o_state     = r_state;

endmodule

// File: tb/tb_sti_dac_bank_writer.sv
// Directed bench for sti_dac_bank_writer with a write scoreboard and a
// serial-bit scoreboard. Define STI_DAC_PARITY_EN to also check parity bits.
module tb_sti_dac_bank_writer;
  import sti_dac_pkg::*;

  localparam int NB  = 4;
  localparam int BD  = 32;
  localparam int IW  = 8;
  localparam int CAP = NB * 2 * BD;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        pi_ready;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_msb, pi_low, pi_fill, pi_end;
  logic        so_data, so_valid, so_parity;
  logic [NB-1:0] odd_wr, even_wr;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_dataout;
  logic        oem_finish;
  state_t      o_state;

  sti_dac_bank_writer #(.NUM_BANK(NB), .BANK_DEPTH(BD), .IMG_W(IW)) dut (
    .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready),
    .pi_data(pi_data), .pi_length(pi_length), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_fill(pi_fill), .pi_end(pi_end),
    .so_data(so_data), .so_valid(so_valid), .so_parity(so_parity),
    .odd_wr(odd_wr), .even_wr(even_wr), .oem_addr(oem_addr),
    .oem_dataout(oem_dataout), .oem_finish(oem_finish), .o_state(o_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];   // {is_odd, bank[1:0], addr[4:0], data[7:0]}
  logic        bit_q[$];
  logic        par_q[$];
  int model_p = 0;
  int mon_strobes = 0;
  bit chk_fin = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rec_for(input int p, input logic [7:0] d);
    int bank, addr, row, col;
    logic odd;
    logic [1:0] b2;
    logic [4:0] a5;
    bank = p / (2 * BD);
    addr = (p % (2 * BD)) / 2;
    row  = p / IW;
    col  = p % IW;
    odd  = ((row + col) % 2) == 0;
    b2   = bank[1:0];
    a5   = addr[4:0];
    return {odd, b2, a5, d};
  endfunction

  // Reference: expand one word into its transmitted bits and bytes.
  task automatic push_word(input logic [15:0] d, input logic [1:0] len,
                           input logic msb, input logic low, input logic fill);
    logic [31:0] v;
    logic [7:0]  by;
    logic        b, par;
    int nb;
    nb  = 8 * (int'(len) + 1);
    par = 1'b0;
    by  = 8'h0;
    case (len)
      2'd0: v = low ? {24'h0, d[15:8]} : {24'h0, d[7:0]};
      2'd1: v = {16'h0, d};
      2'd2: v = fill ? ({16'h0, d} << 8) : {16'h0, d};
      default: v = fill ? ({16'h0, d} << 16) : {16'h0, d};
    endcase
    for (int i = 0; i < nb; i++) begin
      b = msb ? v[nb - 1 - i] : v[i];
      bit_q.push_back(b);
      par = par ^ b;
      by  = {by[6:0], b};
      if ((i % 8) == 7) begin
        if (model_p < CAP) begin
          exp_q.push_back(rec_for(model_p, by));
          model_p++;
        end
      end
    end
`ifdef STI_DAC_PARITY_EN
    par_q.push_back(par);
`endif
  endtask

  task automatic push_pad();
    while (model_p < CAP) begin
      exp_q.push_back(rec_for(model_p, 8'h00));
      model_p++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      mon_strobes = 0;
      chk_fin = 1'b0;
    end else begin
      logic [15:0] obs, exp;
      logic [1:0]  bk;
      if (chk_fin) begin
        chk("finish_rise", oem_finish, 1);
        chk_fin = 1'b0;
      end
`ifdef STI_DAC_PARITY_EN
      if (so_valid && so_parity) begin
        chk("par_q_nonempty", par_q.size() != 0, 1);
        if (par_q.size() != 0) chk("parity_bit", so_data, par_q.pop_front());
      end
`else
      chk("so_parity_zero", so_parity, 0);
`endif
      if (so_valid && !so_parity) begin
        chk("bit_q_nonempty", bit_q.size() != 0, 1);
        if (bit_q.size() != 0) chk("so_data", so_data, bit_q.pop_front());
      end
      if (|{odd_wr, even_wr}) begin
        chk("strobe_onehot", $onehot({odd_wr, even_wr}), 1);
        chk("finish_low_at_strobe", oem_finish, 0);
        bk = 2'd0;
        for (int b = 0; b < NB; b++)
          if (odd_wr[b] || even_wr[b]) bk = 2'(b);
        obs = {|odd_wr, bk, oem_addr, oem_dataout};
        chk("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          chk("write_rec", obs, exp);
        end
        mon_strobes++;
        if (mon_strobes == CAP) chk_fin = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic flush_model();
    exp_q.delete();
    bit_q.delete();
    par_q.delete();
    model_p = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    flush_model();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!pi_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", pi_ready, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] len,
                      input logic msb, input logic low, input logic fill);
    @(negedge clk);
    wait_ready();
    load = 1'b1; pi_end = 1'b0;
    pi_data = d; pi_length = len; pi_msb = msb; pi_low = low; pi_fill = fill;
    push_word(d, len, msb, low, fill);
    @(posedge clk);
    @(negedge clk);
    // Scramble the config inputs: the frame in flight must not see them.
    load      = 1'b0;
    pi_data   = 16'($urandom);
    pi_length = 2'($urandom_range(0, 3));
    pi_msb    = 1'($urandom_range(0, 1));
    pi_low    = 1'($urandom_range(0, 1));
    pi_fill   = 1'($urandom_range(0, 1));
    chk("conv_valid_low", so_valid, 0);
    chk("conv_state", o_state, CONV);
    @(negedge clk);
    chk("first_bit_valid", so_valid, 1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bit_q.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size() + bit_q.size(), 0);
  endtask

  task automatic wait_finish();
    int k;
    k = 0;
    while (!oem_finish && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("finish_timeout", oem_finish, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_done();
    load = 1'b1;
    pi_data = 16'hFFFF;
    repeat (8) begin
      @(negedge clk);
      chk("done_ready_low", pi_ready, 0);
      chk("done_no_valid", so_valid, 0);
      chk("done_state", o_state, DONE);
      chk("done_finish", oem_finish, 1);
    end
    load = 1'b0;
    chk("all_writes_seen", exp_q.size(), 0);
    chk("strobe_count", mon_strobes, CAP);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_odd_wr"}, odd_wr, 0);
    chk({tag, "_even_wr"}, even_wr, 0);
    chk({tag, "_addr"}, oem_addr, 0);
    chk({tag, "_dout"}, oem_dataout, 0);
    chk({tag, "_finish"}, oem_finish, 0);
    chk({tag, "_valid"}, so_valid, 0);
    chk({tag, "_data"}, so_data, 0);
    chk({tag, "_parity"}, so_parity, 0);
    chk({tag, "_state"}, o_state, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; load = 1'b0; pi_end = 1'b0;
    pi_data = 16'h0; pi_length = 2'd0; pi_msb = 1'b0; pi_low = 1'b0; pi_fill = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;

    // 8-bit frames: C3 MSB-first, then 01 LSB-first (byte 80).
    send(16'hA5C3, 2'd0, 1'b1, 1'b0, 1'b0);
    send(16'h0001, 2'd0, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // 32-bit fill frame from p=0, then enough mixed frames to cross row and bank.
    do_reset();
    send(16'h1234, 2'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 28; i++)
      send(16'($urandom), 2'(i % 4), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_drain();

    // pi_end alone: pad the rest with zeros, then terminal DONE.
    @(negedge clk);
    wait_ready();
    pi_end = 1'b1;
    push_pad();
    @(posedge clk);
    @(negedge clk);
    pi_end = 1'b0;
    chk("pad_state", o_state, PAD);
    chk("pad_valid_low", so_valid, 0);
    wait_finish();
    check_done();

    // Reset in the middle of a shifting frame aborts it with no write.
    do_reset();
    send(16'hBEEF, 2'd3, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    flush_model();
    #1;
    check_outputs_zero("midshift_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_strobe", {odd_wr, even_wr}, 0);
    end

    // pi_end and load together: word is dropped, all 256 bytes are padding.
    wait_ready();
    load = 1'b1; pi_end = 1'b1; pi_data = 16'h5A5A; pi_length = 2'd1;
    push_pad();
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; pi_end = 1'b0;
    chk("end_over_load_state", o_state, PAD);
    chk("end_over_load_valid", so_valid, 0);
    wait_finish();
    check_done();
    chk("no_stray_bits", bit_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
